// File: rtl/stream_source_gen.sv
// rtl/stream_source_gen.sv - valid/ready byte-stream burst source, counter or LFSR pattern
// Optional stall counter output enabled by defining STREAM_SOURCE_STALL_CNT_EN.
module stream_source_gen #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LEN_WIDTH  = 8,
    parameter int                    GAP_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic                  stream_out_ready,
    output logic                  stream_out_valid,
    output logic [DATA_WIDTH-1:0] stream_out_data,
    output logic                  stream_out_last,
    output logic                  busy,
    output logic                  done,
`ifdef STREAM_SOURCE_STALL_CNT_EN
    output logic [15:0]           stall_count,
`endif
    output logic [LEN_WIDTH-1:0]  beat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_count_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic                  mode_q;
    logic                  is_last;
    logic                  accept;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE = LEN_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]  GAP_ONE = GAP_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] DAT_ONE = DATA_WIDTH'(1);

    function automatic logic [DATA_WIDTH-1:0] next_value(input logic m,
                                                         input logic [DATA_WIDTH-1:0] d);
        if (m)
            return {d[DATA_WIDTH-2:0], ^(d & LFSR_TAPS)};
        else
            return d + DAT_ONE;
    endfunction

    assign is_last = (beat_count_q == len_q - LEN_ONE);
    assign accept  = (state == SEND) && stream_out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d          = state;
        stream_out_valid = 1'b0;
        stream_out_last  = 1'b0;
        done             = 1'b0;
        busy             = (state != IDLE);
        case (state)
            IDLE: begin
                if (start)
                    state_d = (burst_len == '0) ? FIN : SEND;
            end
            SEND: begin
                stream_out_valid = 1'b1;
                stream_out_last  = is_last;
                if (stream_out_ready) begin
                    if (is_last)
                        state_d = FIN;
                    else if (gap_q != '0)
                        state_d = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_ONE)
                    state_d = SEND;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst parameters are captured only when a start is taken in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= '0;
            len_q        <= '0;
            gap_q        <= '0;
            gap_cnt      <= '0;
            mode_q       <= 1'b0;
            beat_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q       <= mode;
                        len_q        <= burst_len;
                        gap_q        <= gap_cycles;
                        beat_count_q <= '0;
                        data_q       <= (mode && seed == '0) ? DAT_ONE : seed;
                    end
                end
                SEND: begin
                    if (accept) begin
                        beat_count_q <= beat_count_q + LEN_ONE;
                        data_q       <= next_value(mode_q, data_q);
                        gap_cnt      <= gap_q;
                    end
                end
                GAP:     gap_cnt <= gap_cnt - GAP_ONE;
                default: ;
            endcase
        end
    end

`ifdef STREAM_SOURCE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (state == IDLE && start)
            stall_count <= '0;
        else if (state == SEND && !stream_out_ready && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
    end
`endif

    assign stream_out_data = data_q;
    assign beat_count      = beat_count_q;

endmodule

// File: tb/tb_stream_source_gen.sv
// tb/tb_stream_source_gen.sv - directed self-checking bench for stream_source_gen
module tb_stream_source_gen;

    logic       clk = 1'b0;
    logic       rst, start, mode, ready;
    logic [7:0] seed, burst_len;
    logic [3:0] gap_cycles;
    logic       valid, last, busy, done;
    logic [7:0] data, beat_count;
`ifdef STREAM_SOURCE_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_source_gen dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mode             (mode),
        .seed             (seed),
        .burst_len        (burst_len),
        .gap_cycles       (gap_cycles),
        .stream_out_ready (ready),
        .stream_out_valid (valid),
        .stream_out_data  (data),
        .stream_out_last  (last),
        .busy             (busy),
        .done             (done),
`ifdef STREAM_SOURCE_STALL_CNT_EN
        .stall_count      (stall_count),
`endif
        .beat_count       (beat_count)
    );

    // Leaves the bench at the negedge where the first SEND cycle is visible.
    task automatic pulse_start(input logic [7:0] s, input logic [7:0] len,
                               input logic [3:0] gap, input logic m);
        @(negedge clk);
        seed = s; burst_len = len; gap_cycles = gap; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b1;
        seed = 8'h00; burst_len = 8'h00; gap_cycles = 4'h0;
        repeat (3) @(negedge clk);
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
        vectors++; if (last !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b exp 0", last); end
        vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h exp 00", data); end
        vectors++; if (beat_count !== 8'h00) begin miscompares++; $display("FAIL reset_beat_count got %0d exp 0", beat_count); end
        rst = 1'b0;
    endtask

    task automatic test_counter();
        logic [7:0] exp;
        ready = 1'b1;
        pulse_start(8'h10, 8'd4, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp = 8'h10 + 8'(i);
            vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL counter_valid beat %0d got %b exp 1", i, valid); end
            vectors++; if (data !== exp) begin miscompares++; $display("FAIL counter_data beat %0d got %h exp %h", i, data, exp); end
            vectors++; if (last !== (i == 3)) begin miscompares++; $display("FAIL counter_last beat %0d got %b exp %b", i, last, (i == 3)); end
            vectors++; if (beat_count !== 8'(i)) begin miscompares++; $display("FAIL counter_beat_count beat %0d got %0d exp %0d", i, beat_count, i); end
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL counter_busy beat %0d got %b exp 1", i, busy); end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL counter_done got done=%b valid=%b exp 1/0", done, valid); end
        @(negedge clk);
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL counter_idle got done=%b busy=%b exp 0/0", done, busy); end
        vectors++; if (beat_count !== 8'd4) begin miscompares++; $display("FAIL counter_final_count got %0d exp 4", beat_count); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [3];
        exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00;
        pulse_start(8'hFE, 8'd3, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (valid !== 1'b1 || data !== exp[i]) begin miscompares++; $display("FAIL wrap_data beat %0d got valid=%b data=%h exp 1/%h", i, valid, data, exp[i]); end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %b exp 1", done); end
        @(negedge clk);
        vectors++; if (beat_count !== 8'd3) begin miscompares++; $display("FAIL wrap_beat_count got %0d exp 3", beat_count); end
    endtask

    task automatic test_gap();
        logic [6:0] pat;
        logic [7:0] exp;
        pat = 7'b1001001;
        exp = 8'h20;
        pulse_start(8'h20, 8'd3, 4'd2, 1'b0);
        for (int c = 0; c < 7; c++) begin
            vectors++; if (valid !== pat[c]) begin miscompares++; $display("FAIL gap_valid cycle %0d got %b exp %b", c, valid, pat[c]); end
            if (pat[c]) begin
                vectors++; if (data !== exp) begin miscompares++; $display("FAIL gap_data cycle %0d got %h exp %h", c, data, exp); end
                exp = exp + 8'd1;
            end
            @(negedge clk);
        end
        vectors++; if (done !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL gap_done_no_trailing_gap got done=%b valid=%b exp 1/0", done, valid); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        pulse_start(8'h30, 8'd4, 4'd0, 1'b0);
        @(negedge clk);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (valid !== 1'b1 || data !== 8'h31 || last !== 1'b0) begin miscompares++; $display("FAIL stall_hold cycle %0d got valid=%b data=%h last=%b exp 1/31/0", k, valid, data, last); end
        end
        ready = 1'b1;
        @(negedge clk);
        vectors++; if (data !== 8'h32) begin miscompares++; $display("FAIL stall_resume got %h exp 32", data); end
        @(negedge clk);
        vectors++; if (data !== 8'h33 || last !== 1'b1) begin miscompares++; $display("FAIL stall_last got data=%h last=%b exp 33/1", data, last); end
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got %b exp 1", done); end
`ifdef STREAM_SOURCE_STALL_CNT_EN
        vectors++; if (stall_count !== 16'd5) begin miscompares++; $display("FAIL stall_count got %0d exp 5", stall_count); end
`endif
        @(negedge clk);
    endtask

    task automatic test_lfsr();
        logic [7:0] exp [5];
        exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h04; exp[3] = 8'h08; exp[4] = 8'h11;
        pulse_start(8'h00, 8'd5, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (valid !== 1'b1 || data !== exp[i]) begin miscompares++; $display("FAIL lfsr_data beat %0d got valid=%b data=%h exp 1/%h", i, valid, data, exp[i]); end
            if (i == 1) begin
                seed = 8'h55; burst_len = 8'd9; mode = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL lfsr_done got %b exp 1", done); end
        @(negedge clk);
        vectors++; if (beat_count !== 8'd5) begin miscompares++; $display("FAIL lfsr_ignored_start_count got %0d exp 5", beat_count); end
        @(negedge clk);
        vectors++; if (valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL lfsr_no_queued_burst got valid=%b busy=%b exp 0/0", valid, busy); end
    endtask

    task automatic test_zero_len();
        pulse_start(8'h77, 8'd0, 4'd0, 1'b0);
        vectors++; if (done !== 1'b1 || valid !== 1'b0) begin miscompares++; $display("FAIL zero_len_done got done=%b valid=%b exp 1/0", done, valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL zero_len_busy got %b exp 1", busy); end
        @(negedge clk);
        vectors++; if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin miscompares++; $display("FAIL zero_len_after got done=%b busy=%b valid=%b exp 0/0/0", done, busy, valid); end
    endtask

    task automatic test_rst_mid();
        logic saw_done;
        saw_done = 1'b0;
        pulse_start(8'h40, 8'd4, 4'd0, 1'b0);
        @(negedge clk);
        vectors++; if (data !== 8'h41) begin miscompares++; $display("FAIL rst_mid_pre got %h exp 41", data); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_outputs got valid=%b busy=%b done=%b exp 0/0/0", valid, busy, done); end
        vectors++; if (data !== 8'h00 || beat_count !== 8'h00) begin miscompares++; $display("FAIL rst_mid_state got data=%h count=%0d exp 00/0", data, beat_count); end
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_done got %b exp 0", saw_done); end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_wrap();
        test_gap();
        test_stall();
        test_lfsr();
        test_zero_len();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
